// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding,
// stage index width rule and output polarity mapping.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_WAIT_DLY,
    ST_RELEASE,
    ST_WAIT_RDY,
    ST_DONE,
    ST_UNWIND,
    ST_ERROR
  } seq_state_e;

  localparam int MIN_STAGES = 1;
  localparam int MAX_STAGES = 16;

  // One extra bit over the minimum so a count of NUM_STAGES is representable.
  function automatic int stage_idx_w(input int num_stages);
    return $clog2(num_stages) + 1;
  endfunction

  // Maps an internal "asserted" flag onto the pin level.
  function automatic logic rst_level(input logic asserted, input bit active_high);
    return active_high ? asserted : !asserted;
  endfunction

endpackage

// File: rtl/reset_seq_delay.sv
// Loadable up-counter that stops at a programmable terminal value and flags it.
// Used for both the inter-stage delay and the ready timeout.
module reset_seq_delay #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == terminal);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in index order, each gated by its ready ack;
// a soft request unwinds them highest-first and restarts. Optional ready
// timeout is enabled with `define RESET_SEQ_TIMEOUT_EN.
//
// state      | meaning
// HOLD       | all stages asserted, one cycle before sequencing starts
// WAIT_DLY   | counting the gap before releasing stage stage_idx
// RELEASE    | stage stage_idx just deasserted
// WAIT_RDY   | waiting for stage_ready[stage_idx]
// DONE       | every stage released and acknowledged
// UNWIND     | re-asserting released stages, one per cycle, highest first
// ERROR      | a stage missed its ready deadline, all stages asserted
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int  NUM_STAGES   = 4,
  parameter int  DELAY_W      = 8,
  parameter int  STAGE_DELAY  = 16,
  parameter bit  POLARITY_OUT = 1'b1,
  parameter int  TIMEOUT      = 255,
  localparam int IDX_W        = stage_idx_w(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  soft_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic [IDX_W-1:0]      stage_idx,
  output logic                  seq_done,
  output logic                  seq_error
);

  seq_state_e            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] act_q, act_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  dly_tc;
  logic                  tmo_tc;
  logic                  ready_sel;
  logic                  any_rel;
  logic [IDX_W-1:0]      top_rel;
  logic                  is_last;

  reset_seq_delay #(.W(DELAY_W)) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q != ST_WAIT_DLY),
    .en       (1'b1),
    .terminal (DELAY_W'(STAGE_DELAY)),
    .tc       (dly_tc)
  );

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // Counter reads 0 on the first WAIT_RDY cycle, so TIMEOUT-1 marks the last one.
  reset_seq_delay #(.W(TO_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q != ST_WAIT_RDY),
    .en       (1'b1),
    .terminal (TO_W'(TIMEOUT - 1)),
    .tc       (tmo_tc)
  );
`else
  assign tmo_tc = 1'b0;
`endif

  always_comb begin
    ready_sel = 1'b0;
    any_rel   = 1'b0;
    top_rel   = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        ready_sel = stage_ready[i];
      end
      if (!act_q[i]) begin
        any_rel = 1'b1;
        top_rel = IDX_W'(i);
      end
    end
  end

  assign is_last = (idx_q == IDX_W'(NUM_STAGES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    act_d   = act_q;
    done_d  = done_q;
    err_d   = err_q;
    if (soft_rst_req && (state_q inside {ST_WAIT_DLY, ST_RELEASE, ST_WAIT_RDY,
                                         ST_DONE, ST_ERROR})) begin
      state_d = ST_UNWIND;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: state_d = ST_WAIT_DLY;
        ST_WAIT_DLY: begin
          if (dly_tc) begin
            state_d = ST_RELEASE;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (IDX_W'(i) == idx_q) act_d[i] = 1'b0;
            end
          end
        end
        ST_RELEASE: state_d = ST_WAIT_RDY;
        ST_WAIT_RDY: begin
          if (ready_sel) begin
            if (is_last) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT_DLY;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else if (tmo_tc) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
            act_d   = '1;
          end
        end
        ST_DONE, ST_ERROR: state_d = state_q;
        ST_UNWIND: begin
          if (any_rel) begin
            idx_d = top_rel;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (IDX_W'(i) == top_rel) act_d[i] = 1'b1;
            end
          end else begin
            idx_d   = '0;
            state_d = ST_HOLD;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      act_q   <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rst_out = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      rst_out[i] = rst_level(act_q[i], POLARITY_OUT);
    end
  end

  assign stage_idx = idx_q;
  assign seq_done  = done_q;
  assign seq_error = err_q;

endmodule
